sd_read_arbiter: RTL and testbench

Shares one SD-card `sd_controller` read port between two requesters: the song-list/menu reader and the audio streamer. Each grant performs one full sector read, and the arbiter streams that sector's bytes back to the granted requester. Requesters name a sector index; the arbiter sequences `rd`/`address`, detects byte strobes, counts the block and reports completion. It sits between `sd_controller` and the playback/selection logic on the system clock.

---
 rtl/sd_read_arbiter.sv | 146 ++++++++++++++
 tb/tb_sd_read_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sd_read_arbiter.sv
// Two-requester arbiter in front of one sd_controller read port: grants one full sector read and streams its bytes back.
// Build option SD_ARB_SDHC_EN: defined = block addressing (sector as-is), undefined = byte addressing (sector * BLOCK_BYTES).
module sd_read_arbiter #(
    parameter int BLOCK_BYTES = 512
) (
    input  logic        clk_100mhz,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [31:0] sector0,
    input  logic [31:0] sector1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [7:0]  rdata,
    output logic        rvalid,
    output logic        rlast,
    output logic        busy,
    input  logic        sd_ready,
    input  logic [7:0]  sd_dout,
    input  logic        sd_byte_available,
    output logic        sd_rd,
    output logic [31:0] sd_addr
);

    localparam int SHIFT = $clog2(BLOCK_BYTES);
    localparam int CW    = SHIFT + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, STREAM, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          rlast_q, rlast_d;
    logic          sd_rd_q, sd_rd_d;
    logic [31:0]   sd_addr_q, sd_addr_d;
    logic          last_gnt_q, last_gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bav_prev_q;

    logic [1:0]    req_eff;
    logic          byte_edge;
    logic          win;

    function automatic logic [31:0] map_addr(input logic [31:0] sector);
`ifdef SD_ARB_SDHC_EN
        return sector;
`else
        return sector << SHIFT;
`endif
    endfunction

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        done_d     = 2'b00;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        rlast_d    = 1'b0;
        sd_rd_d    = sd_rd_q;
        sd_addr_d  = sd_addr_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        win        = 1'b0;
        // The requester being told it is done cannot be re-granted in that same cycle.
        req_eff    = req & ~done_q;
        byte_edge  = sd_byte_available & ~bav_prev_q;

        case (state_q)
            IDLE: begin
                if (sd_ready && (req_eff != 2'b00)) begin
                    win       = (req_eff == 2'b11) ? ~last_gnt_q : req_eff[1];
                    gnt_d     = win ? 2'b10 : 2'b01;
                    sd_addr_d = map_addr(win ? sector1 : sector0);
                    sd_rd_d   = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (!sd_ready) begin
                    sd_rd_d = 1'b0;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (byte_edge) begin
                    rdata_d  = sd_dout;
                    rvalid_d = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(BLOCK_BYTES - 1)) begin
                        rlast_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (sd_ready) begin
                    done_d     = gnt_q;
                    last_gnt_d = gnt_q[1];
                    gnt_d      = 2'b00;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            rdata_q    <= 8'h00;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            sd_rd_q    <= 1'b0;
            sd_addr_q  <= 32'h0;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            bav_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            sd_rd_q    <= sd_rd_d;
            sd_addr_q  <= sd_addr_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            bav_prev_q <= sd_byte_available;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign busy    = (state_q != IDLE);
    assign sd_rd   = sd_rd_q;
    assign sd_addr = sd_addr_q;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Directed bench for sd_read_arbiter: a table of whole-sector transfers plus reset/abort/spurious-strobe corner cases.
module tb_sd_read_arbiter;

    localparam int BB = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [31:0] s0 = 32'h0, s1 = 32'h0;
    logic [1:0]  gnt, done;
    logic [7:0]  rdata;
    logic        rvalid, rlast, busy;
    logic        sd_ready = 1'b1;
    logic [7:0]  sd_dout = 8'h00;
    logic        bav = 1'b0;
    logic        sd_rd;
    logic [31:0] sd_addr;

    int tests = 0;
    int fails = 0;
    int mon_idx = 0;
    logic stream_on = 1'b0;
    logic stream_prev = 1'b0;

    sd_read_arbiter #(.BLOCK_BYTES(BB)) dut (
        .clk_100mhz(clk), .rst(rst), .req(req), .sector0(s0), .sector1(s1),
        .gnt(gnt), .done(done), .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .busy(busy),
        .sd_ready(sd_ready), .sd_dout(sd_dout), .sd_byte_available(bav),
        .sd_rd(sd_rd), .sd_addr(sd_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [31:0] s0;
        logic [31:0] s1;
        logic [1:0]  req_after;
        logic [1:0]  exp_gnt;
        logic [31:0] exp_addr;
        int          per;
        int          hi;
        int          drop_at;
        int          rst_at;
    } xfer_t;

    xfer_t tbl [10];

    function automatic logic [31:0] pick(input logic [31:0] sdsc, input logic [31:0] sdhc);
`ifdef SD_ARB_SDHC_EN
        return sdhc;
`else
        return sdsc;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte monitor: every rvalid must fall inside a transfer and carry the next byte of the block.
    always @(negedge clk) begin
        if (stream_on && !stream_prev) mon_idx = 0;
        stream_prev = stream_on;
        if (rvalid) begin
            if (!stream_on) chk("rvalid_outside_stream", {31'b0, rvalid}, 32'd0);
            else begin
                chk("rdata", {24'b0, rdata}, 32'(mon_idx & 255));
                chk("rlast", {31'b0, rlast}, {31'b0, (mon_idx == BB - 1)});
                mon_idx++;
            end
        end else begin
            if (rlast) chk("rlast_without_rvalid", {31'b0, rvalid}, 32'd1);
            if (stream_on && mon_idx > 0) chk("rdata_hold", {24'b0, rdata}, 32'((mon_idx - 1) & 255));
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, {30'b0, gnt}, 32'd0);
        chk({tag, "_done"}, {30'b0, done}, 32'd0);
        chk({tag, "_rdata"}, {24'b0, rdata}, 32'd0);
        chk({tag, "_rvalid"}, {31'b0, rvalid}, 32'd0);
        chk({tag, "_rlast"}, {31'b0, rlast}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_sd_rd"}, {31'b0, sd_rd}, 32'd0);
        chk({tag, "_sd_addr"}, sd_addr, 32'd0);
    endtask

    task automatic run_xfer(input xfer_t t);
        int n;
        logic was_idle;
        if (req == 2'b00 && gnt == 2'b00) begin
            repeat (3) begin
                bav = 1'b1; @(negedge clk);
                bav = 1'b0; @(negedge clk);
            end
        end
        s0 = t.s0;
        s1 = t.s1;
        was_idle = (gnt == 2'b00);
        req = t.req;
        n = 0;
        while (gnt == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (was_idle) chk("grant_latency", n, 32'd1);
        chk("gnt", {30'b0, gnt}, {30'b0, t.exp_gnt});
        chk("sd_addr", sd_addr, t.exp_addr);
        chk("sd_rd_issue", {31'b0, sd_rd}, 32'd1);
        chk("busy_issue", {31'b0, busy}, 32'd1);
        repeat (2) begin
            bav = 1'b1; @(negedge clk);
            bav = 1'b0; @(negedge clk);
        end
        chk("sd_rd_held", {31'b0, sd_rd}, 32'd1);
        sd_ready = 1'b0;
        @(negedge clk);
        chk("sd_rd_drop", {31'b0, sd_rd}, 32'd0);
        stream_on = 1'b1;
        for (int i = 0; i < BB; i++) begin
            if (i == t.rst_at) begin
                stream_on = 1'b0;
                rst = 1'b1;
                #1;
                check_all_zero("async_reset");
                req = 2'b00;
                sd_ready = 1'b1;
                bav = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("no_done_after_reset", {30'b0, done}, 32'd0);
                    chk("no_gnt_after_reset", {30'b0, gnt}, 32'd0);
                end
                return;
            end
            if (i == t.drop_at) req = 2'b00;
            sd_dout = i[7:0];
            bav = 1'b1;
            repeat (t.hi) @(negedge clk);
            bav = 1'b0;
            repeat (t.per - t.hi) @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        chk("byte_count", mon_idx, BB);
        chk("busy_stream", {31'b0, busy}, 32'd1);
        chk("gnt_hold", {30'b0, gnt}, {30'b0, t.exp_gnt});
        chk("done_early", {30'b0, done}, 32'd0);
        stream_on = 1'b0;
        sd_ready = 1'b1;
        @(negedge clk);
        n = 1;
        while (done == 2'b00 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("done_latency", n, 32'd1);
        chk("done", {30'b0, done}, {30'b0, t.exp_gnt});
        chk("gnt_cleared", {30'b0, gnt}, 32'd0);
        chk("busy_cleared", {31'b0, busy}, 32'd0);
        req = t.req_after;
        @(negedge clk);
        chk("done_one_cycle", {30'b0, done}, 32'd0);
    endtask

    initial begin
        //            req    s0     s1        after  gnt    addr                                per hi drop  rst
        tbl[0] = '{2'b11, 32'd7, 32'd9,     2'b10, 2'b01, pick(32'h0000_0E00, 32'd7),      4, 2, -1,  -1};
        tbl[1] = '{2'b11, 32'd7, 32'd9,     2'b01, 2'b10, pick(32'h0000_1200, 32'd9),      4, 2, -1,  -1};
        tbl[2] = '{2'b11, 32'd7, 32'd9,     2'b10, 2'b01, pick(32'h0000_0E00, 32'd7),      4, 2, -1,  -1};
        tbl[3] = '{2'b11, 32'd7, 32'd9,     2'b00, 2'b10, pick(32'h0000_1200, 32'd9),      4, 2, -1,  -1};
        tbl[4] = '{2'b01, 32'd1, 32'h1234,  2'b00, 2'b01, pick(32'h0000_0200, 32'd1),      4, 2, -1,  -1};
        tbl[5] = '{2'b10, 32'd1, 32'h1234,  2'b00, 2'b10, pick(32'h0024_6800, 32'h1234),   4, 2, -1,  -1};
        tbl[6] = '{2'b01, 32'd2, 32'd0,     2'b00, 2'b01, pick(32'h0000_0400, 32'd2),     16, 3, -1,  -1};
        tbl[7] = '{2'b01, 32'd3, 32'd0,     2'b00, 2'b01, pick(32'h0000_0600, 32'd3),      4, 2, 100, -1};
        tbl[8] = '{2'b01, 32'd4, 32'd0,     2'b00, 2'b01, pick(32'h0000_0800, 32'd4),      4, 2, -1,  300};
        tbl[9] = '{2'b11, 32'd5, 32'd6,     2'b00, 2'b01, pick(32'h0000_0A00, 32'd5),      4, 2, -1,  -1};

        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");

        for (int e = 0; e < 10; e++) run_xfer(tbl[e]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
